// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared definitions for the UART TX frame controller: FSM state codes,
// line levels and parity type codes.
package uart_tx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_ctrl_parity_calc.sv
// Combinational N-bit parity; odd_i flips the result so the frame's total
// count of ones (data + parity bit) comes out even or odd as selected.
module uart_parity_calc #(
  parameter int N = 8
) (
  input  logic [N-1:0] data_i,
  input  logic         odd_i,
  output logic         par_o
);

  // Reduction XOR gives even parity; XOR with the type selects odd.
  always_comb begin
    par_o = (^data_i) ^ odd_i;
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller. Latches one byte per handshake, sequences
// start -> data (from the serializer) -> optional parity -> stop at one bit
// per clock, and cross-checks the serializer done pulse against a local
// shadow count of data bits.
module uart_tx_frame_ctrl
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                TxCtrl_CLK,
  input  logic                TxCtrl_RST_ASYN,
  input  logic [2**WIDTH-1:0] TxCtrl_DataIn,
  input  logic                TxCtrl_DataValid,
  input  logic                TxCtrl_ParEn,
  input  logic                TxCtrl_ParType,
  input  logic                TxCtrl_SerDone,
  input  logic                TxCtrl_SerData,
  output logic [2**WIDTH-1:0] TxCtrl_SerParallel,
  output logic                TxCtrl_SerEn,
  output logic                TxCtrl_TxOut,
  output logic                TxCtrl_Busy,
  output logic                TxCtrl_FrameErr
);

  localparam int N = 2**WIDTH;
  localparam logic [WIDTH-1:0] LAST_BIT = WIDTH'(N-1);

  tx_state_e        state_q, state_d;
  logic [N-1:0]     data_q, data_d;
  logic             par_q, par_d;
  logic             par_en_q, par_en_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             err_q, err_d;

  logic par_calc;
  logic accept;
  logic last_bit;

  uart_parity_calc #(.N(N)) u_parity (
    .data_i (TxCtrl_DataIn),
    .odd_i  (TxCtrl_ParType),
    .par_o  (par_calc)
  );

  // A new byte is only taken when the line is idle or finishing a stop bit,
  // which is what allows back-to-back frames with no idle gap.
  assign accept   = TxCtrl_DataValid && ((state_q == ST_IDLE) || (state_q == ST_STOP));
  assign last_bit = (shadow_q == LAST_BIT);

  // Next-state, latch and shadow-counter logic.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    shadow_d = shadow_q;
    // Done must coincide with the last data bit; anything else is flagged.
    err_d    = (state_q == ST_DATA) && (TxCtrl_SerDone != last_bit);
    case (state_q)
      ST_IDLE, ST_STOP: begin
        if (accept) begin
          data_d   = TxCtrl_DataIn;
          par_d    = par_calc;
          par_en_d = TxCtrl_ParEn;
          shadow_d = '0;
          state_d  = ST_START;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_START: begin
        shadow_d = '0;
        state_d  = ST_DATA;
      end
      ST_DATA: begin
        shadow_d = shadow_q + WIDTH'(1);
        // Leave on our own count; SerDone is only checked, never trusted.
        if (last_bit) state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: state_d = ST_STOP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops the line immediately.
  always_ff @(posedge TxCtrl_CLK or negedge TxCtrl_RST_ASYN) begin
    if (!TxCtrl_RST_ASYN) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  // Line mux and status outputs decoded from the state register.
  always_comb begin
    TxCtrl_TxOut = LINE_IDLE;
    TxCtrl_Busy  = 1'b1;
    TxCtrl_SerEn = 1'b0;
    case (state_q)
      ST_IDLE:   TxCtrl_Busy  = 1'b0;
      ST_START:  TxCtrl_TxOut = LINE_START;
      ST_DATA: begin
        TxCtrl_TxOut = TxCtrl_SerData;
        TxCtrl_SerEn = 1'b1;
      end
      ST_PARITY: TxCtrl_TxOut = par_q;
      ST_STOP:   TxCtrl_TxOut = LINE_STOP;
      default:   TxCtrl_Busy  = 1'b0;
    endcase
  end

  assign TxCtrl_SerParallel = data_q;
  assign TxCtrl_FrameErr    = err_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl with a behavioural serializer.
// Expected line/status per cycle is queued when a frame is launched and
// popped one entry per clock.
module tb_uart_tx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dv = 1'b0;
  logic       pen = 1'b0;
  logic       ptype = 1'b0;
  logic       ser_done, ser_data, ser_en, tx, busy, ferr;
  logic [7:0] ser_par;
  logic [2:0] ser_cnt;
  logic       bad_ser = 1'b0;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic tx;
    logic busy;
    logic sen;
    logic err;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  uart_tx_frame_ctrl #(.WIDTH(3)) dut (
    .TxCtrl_CLK         (clk),
    .TxCtrl_RST_ASYN    (rst_n),
    .TxCtrl_DataIn      (din),
    .TxCtrl_DataValid   (dv),
    .TxCtrl_ParEn       (pen),
    .TxCtrl_ParType     (ptype),
    .TxCtrl_SerDone     (ser_done),
    .TxCtrl_SerData     (ser_data),
    .TxCtrl_SerParallel (ser_par),
    .TxCtrl_SerEn       (ser_en),
    .TxCtrl_TxOut       (tx),
    .TxCtrl_Busy        (busy),
    .TxCtrl_FrameErr    (ferr)
  );

  // Serializer model: LSB-first counter; a faulty variant fires done early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ser_cnt <= 3'd0;
    else if (ser_en) ser_cnt <= ser_cnt + 3'd1;
  end
  assign ser_data = ser_par[ser_cnt];
  assign ser_done = ser_en && (bad_ser ? (ser_cnt == 3'd3) : (ser_cnt == 3'd7));

  function automatic void push_one(logic t, logic b, logic s, logic e);
    exp_t x;
    x.tx = t; x.busy = b; x.sen = s; x.err = e;
    q.push_back(x);
  endfunction

  // Expected frame: start, 8 data bits LSB first, optional parity, stop.
  function automatic void push_frame(logic [7:0] d, logic p_en, logic p_t,
                                     logic faulty, logic tail);
    logic p;
    p = logic'($countones(d) % 2) ^ p_t;
    push_one(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) push_one(d[i], 1'b1, 1'b1, faulty && (i == 4));
    if (p_en) push_one(p, 1'b1, 1'b0, faulty);
    push_one(1'b1, 1'b1, 1'b0, faulty && !p_en);
    if (tail) push_one(1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic send(input logic [7:0] d, input logic p_en, input logic p_t, input logic hold);
    @(negedge clk);
    din = d; pen = p_en; ptype = p_t; dv = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) dv = 1'b0;
  endtask

  task automatic check_frames(input string name, input int drop_at,
                              output int sen_cnt, output int err_cnt);
    exp_t e;
    int i;
    i = 0; sen_cnt = 0; err_cnt = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (tx !== e.tx) begin
        bad++; $display("FAIL %s tx idx=%0d got=%b exp=%b", name, i, tx, e.tx);
      end
      total++;
      if (busy !== e.busy) begin
        bad++; $display("FAIL %s busy idx=%0d got=%b exp=%b", name, i, busy, e.busy);
      end
      total++;
      if (ser_en !== e.sen) begin
        bad++; $display("FAIL %s seren idx=%0d got=%b exp=%b", name, i, ser_en, e.sen);
      end
      total++;
      if (ferr !== e.err) begin
        bad++; $display("FAIL %s frameerr idx=%0d got=%b exp=%b", name, i, ferr, e.err);
      end
      if (ser_en === 1'b1) sen_cnt++;
      if (ferr === 1'b1) err_cnt++;
      if (i == drop_at) dv = 1'b0;
      i++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset tx got=%b exp=1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
    total++; if (ser_en !== 1'b0) begin bad++; $display("FAIL reset seren got=%b exp=0", ser_en); end
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL reset frameerr got=%b exp=0", ferr); end
    total++; if (ser_par !== 8'h00) begin bad++; $display("FAIL reset serpar got=%h exp=00", ser_par); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || tx !== 1'b1) begin
      bad++; $display("FAIL idle_after_reset got=%b%b exp=01", busy, tx);
    end
  endtask

  task automatic test_a5_parity_even();
    int sc, ec;
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    push_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    check_frames("a5_even", -1, sc, ec);
    total++; if (sc != 8) begin bad++; $display("FAIL a5_seren_cnt got=%0d exp=8", sc); end
    total++; if (ser_par !== 8'hA5) begin bad++; $display("FAIL a5_serpar got=%h exp=a5", ser_par); end
  endtask

  task automatic test_zero_no_parity();
    int sc, ec;
    send(8'h00, 1'b0, 1'b0, 1'b0);
    push_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check_frames("zero", -1, sc, ec);
    total++; if (sc != 8) begin bad++; $display("FAIL zero_seren_cnt got=%0d exp=8", sc); end
  endtask

  task automatic test_odd_parity();
    int sc, ec;
    send(8'h03, 1'b1, 1'b1, 1'b0);
    push_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
    check_frames("odd_03", -1, sc, ec);
    send(8'h01, 1'b1, 1'b1, 1'b0);
    push_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
    check_frames("odd_01", -1, sc, ec);
  endtask

  task automatic test_back_to_back();
    int sc, ec;
    send(8'hA5, 1'b1, 1'b0, 1'b1);
    // Source keeps DataValid up and presents the next byte mid-frame.
    din = 8'h5A; pen = 1'b0; ptype = 1'b1;
    push_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    push_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
    check_frames("b2b", 11, sc, ec);
    total++; if (sc != 16) begin bad++; $display("FAIL b2b_seren_cnt got=%0d exp=16", sc); end
    total++; if (ser_par !== 8'h5A) begin bad++; $display("FAIL b2b_serpar got=%h exp=5a", ser_par); end
  endtask

  task automatic test_reset_mid_frame();
    int sc, ec;
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    total++; if (tx !== 1'b0 || ser_en !== 1'b1) begin
      bad++; $display("FAIL mid_bit3 got tx=%b sen=%b exp tx=0 sen=1", tx, ser_en);
    end
    rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_reset tx got=%b exp=1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset busy got=%b exp=0", busy); end
    total++; if (ser_en !== 1'b0) begin bad++; $display("FAIL mid_reset seren got=%b exp=0", ser_en); end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    push_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    check_frames("after_reset_ff", -1, sc, ec);
  endtask

  task automatic test_bad_serializer();
    int sc, ec;
    bad_ser = 1'b1;
    send(8'h96, 1'b1, 1'b0, 1'b0);
    push_frame(8'h96, 1'b1, 1'b0, 1'b1, 1'b1);
    check_frames("bad_ser", -1, sc, ec);
    total++; if (ec != 2) begin bad++; $display("FAIL bad_ser_err_cnt got=%0d exp=2", ec); end
    total++; if (sc != 8) begin bad++; $display("FAIL bad_ser_seren_cnt got=%0d exp=8", sc); end
    bad_ser = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_a5_parity_even();
    test_zero_no_parity();
    test_odd_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_bad_serializer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
